sar_search_8bit: RTL and testbench

- Successive-approximation search initiator that drives the operand side of an 8-bit magnitude comparator and consumes its greater/equal/less flags.
- Recovers an unknown 8-bit value held on the comparator's B side by binary search, MSB first, with early exit on equality.
- Sits beside the branch/compare datapath as a reusable sequential search engine for threshold and calibration lookups.
- Tolerates any comparator response latency through a valid/valid handshake.

---
 rtl/sar_search_8bit_pkg.sv | 18 +
 rtl/sar_search_8bit.sv | 126 ++++++++++++
 tb/tb_sar_search_8bit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sar_search_8bit_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_search_8bit_pkg;

  localparam int CMP_WIDTH   = 8;
  localparam int TRIAL_CNT_W = $clog2(CMP_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A well-formed comparator response has exactly one of greater/equal/less set.
  function automatic logic flags_onehot(input logic g, input logic e, input logic l);
    return (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  endfunction

endpackage

// File: rtl/sar_search_8bit.sv
// Binary search (MSB first) for the unknown operand on the B side of an
// external magnitude comparator. One trial per handshake, early exit on equal.
module sar_search_8bit
  import sar_search_8bit_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic [WIDTH-1:0]       trial_8,
  output logic                   trial_valid,
  input  logic                   cmp_valid,
  input  logic                   greater_8,
  input  logic                   equal_8,
  input  logic                   less_8,
  output logic                   done,
  output logic [WIDTH-1:0]       result,
  output logic                   found_eq,
  output logic                   err,
  output logic [TRIAL_CNT_W-1:0] trials
);

  localparam int               IDX_W   = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next_state;
  logic [WIDTH-1:0]       r_acc;
  logic [WIDTH-1:0]       r_trial;
  logic [WIDTH-1:0]       r_result;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_found_eq;
  logic                   r_err;
  logic [TRIAL_CNT_W-1:0] r_trials;

  logic                   w_flags_ok;
  logic [WIDTH-1:0]       w_acc_next;
  logic [WIDTH-1:0]       w_next_bit;

  assign w_flags_ok = flags_onehot(greater_8, equal_8, less_8);
  // r_trial is r_acc with the current bit set, so "keep the bit" is just r_trial.
  assign w_acc_next = less_8 ? r_trial : r_acc;
  assign w_next_bit = LSB_ONE << (r_idx - IDX_W'(1));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode; a search ends on a bad flag set, equality, or the last bit.
  // NOTE: assign defaults first in always_comb so no path leaves a signal unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_REQ;
      ST_REQ: begin
        if (cmp_valid && (!w_flags_ok || equal_8 || r_idx == '0)) w_next_state = ST_DONE;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Search datapath: seed on start, fold each comparator response into the accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_trial    <= '0;
      r_result   <= '0;
      r_idx      <= '0;
      r_found_eq <= 1'b0;
      r_err      <= 1'b0;
      r_trials   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc      <= '0;
            r_trial    <= MSB_ONE;
            r_idx      <= IDX_W'(WIDTH - 1);
            r_result   <= '0;
            r_found_eq <= 1'b0;
            r_err      <= 1'b0;
            r_trials   <= '0;
          end
        end
        ST_REQ: begin
          if (cmp_valid) begin
            r_trials <= r_trials + TRIAL_CNT_W'(1);
            if (!w_flags_ok) begin
              r_err    <= 1'b1;
              r_result <= r_acc;
            end else if (equal_8) begin
              r_result   <= r_trial;
              r_found_eq <= 1'b1;
            end else begin
              r_acc <= w_acc_next;
              if (r_idx == '0) begin
                r_result <= w_acc_next;
              end else begin
                r_idx   <= r_idx - IDX_W'(1);
                r_trial <= w_acc_next | w_next_bit;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign trial_8     = r_trial;
  assign trial_valid = (r_state == ST_REQ);
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign result      = r_result;
  assign found_eq    = r_found_eq;
  assign err         = r_err;
  assign trials      = r_trials;

endmodule

// File: tb/tb_sar_search_8bit.sv
// Directed bench: a behavioural comparator sits on trial_8 vs a target, with
// optional response stalls and a forced illegal flag set on a chosen handshake.
module tb_sar_search_8bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic [7:0] trial_8;
  logic       trial_valid;
  logic       cmp_valid;
  logic       greater_8;
  logic       equal_8;
  logic       less_8;
  logic       done;
  logic [7:0] result;
  logic       found_eq;
  logic       err;
  logic [3:0] trials;

  logic [7:0] target;
  logic       inject;

  int tests = 0;
  int fails = 0;

  sar_search_8bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .trial_8     (trial_8),
    .trial_valid (trial_valid),
    .cmp_valid   (cmp_valid),
    .greater_8   (greater_8),
    .equal_8     (equal_8),
    .less_8      (less_8),
    .done        (done),
    .result      (result),
    .found_eq    (found_eq),
    .err         (err),
    .trials      (trials)
  );

  // External comparator: a = trial_8, b = target; inject forces greater & less.
  assign greater_8 = inject ? 1'b1 : (trial_8 > target);
  assign equal_8   = inject ? 1'b0 : (trial_8 == target);
  assign less_8    = inject ? 1'b1 : (trial_8 < target);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one search. Cycle 0 is the cycle start is high; done_cyc is the cycle done is seen.
  task automatic run_search(input string name, input logic [7:0] tgt, input int stall,
                            input int inject_at, input int poke_at,
                            output int done_cyc, output bit stable);
    int         cyc;
    int         wait_cnt;
    int         hs;
    logic [7:0] held;
    cyc      = 0;
    wait_cnt = 0;
    hs       = 0;
    held     = '0;
    stable   = 1'b1;
    target   = tgt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    check({name, " start trial_8"}, 16'(trial_8), 16'h80);
    check({name, " start trial_valid"}, 16'(trial_valid), 16'h1);
    check({name, " start busy"}, 16'(busy), 16'h1);
    check({name, " start cleared"}, {4'h0, 1'b0, err, found_eq, 1'b0, result}, 16'h0000);
    check({name, " start trials"}, 16'(trials), 16'h0);
    while (!done && cyc < 200) begin
      start = (cyc == poke_at);
      if (trial_valid) begin
        if (wait_cnt == 0) held = trial_8;
        else if (trial_8 !== held) stable = 1'b0;
        if (wait_cnt >= stall) begin
          hs++;
          cmp_valid = 1'b1;
          inject    = (hs == inject_at);
          wait_cnt  = 0;
        end else begin
          cmp_valid = 1'b0;
          inject    = 1'b0;
          wait_cnt++;
        end
      end else begin
        cmp_valid = 1'b0;
        inject    = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    cmp_valid = 1'b0;
    inject    = 1'b0;
    done_cyc  = cyc;
    if (!done) check({name, " done timeout"}, 16'(done), 16'h1);
  endtask

  // Checks the DONE cycle, then shows start during DONE is ignored.
  task automatic finish_check(input string name, input logic [7:0] exp_res, input logic exp_found,
                              input logic exp_err, input logic [3:0] exp_trials,
                              input int exp_cyc, input int done_cyc);
    check({name, " done"}, 16'(done), 16'h1);
    check({name, " busy in DONE"}, 16'(busy), 16'h1);
    check({name, " trial_valid in DONE"}, 16'(trial_valid), 16'h0);
    check({name, " result"}, 16'(result), 16'(exp_res));
    check({name, " found_eq"}, 16'(found_eq), 16'(exp_found));
    check({name, " err"}, 16'(err), 16'(exp_err));
    check({name, " trials"}, 16'(trials), 16'(exp_trials));
    check({name, " latency"}, 16'(done_cyc), 16'(exp_cyc));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, " idle busy"}, 16'(busy), 16'h0);
    check({name, " idle done"}, 16'(done), 16'h0);
    check({name, " idle trial_valid"}, 16'(trial_valid), 16'h0);
    check({name, " result held"}, 16'(result), 16'(exp_res));
    @(negedge clk);
    check({name, " start in DONE ignored"}, 16'(busy), 16'h0);
  endtask

  int dc;
  bit st;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    cmp_valid = 1'b0;
    inject    = 1'b0;
    target    = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset outputs",
          {trial_valid, busy, done, found_eq, err, 3'b000, trial_8},
          16'h0000);
    check("reset result", 16'(result), 16'h0);
    check("reset trials", 16'(trials), 16'h0);
    rst = 1'b0;

    // 0x5A: G L G L L G E -> 7 handshakes, early exit.
    run_search("t5a", 8'h5A, 0, 0, -1, dc, st);
    finish_check("t5a", 8'h5A, 1'b1, 1'b0, 4'd7, 8, dc);

    // 0x00: eight greater responses.
    run_search("t00", 8'h00, 0, 0, -1, dc, st);
    finish_check("t00", 8'h00, 1'b0, 1'b0, 4'd8, 9, dc);

    // 0xFF: seven less, then 0xFF compares equal.
    run_search("tff", 8'hFF, 0, 0, -1, dc, st);
    finish_check("tff", 8'hFF, 1'b1, 1'b0, 4'd8, 9, dc);

    // 0x37 with 3 stall cycles per trial; start poked mid-search must be ignored.
    run_search("t37", 8'h37, 3, 0, 6, dc, st);
    check("t37 trial stable while stalled", 16'(st), 16'h1);
    finish_check("t37", 8'h37, 1'b1, 1'b0, 4'd8, 33, dc);

    // Illegal flags on 3rd handshake: 0x80 G, 0x40 L -> acc 0x40, then error.
    run_search("terr", 8'h5A, 0, 3, -1, dc, st);
    finish_check("terr", 8'h40, 1'b0, 1'b1, 4'd3, 4, dc);

    // Next start clears err (checked at cycle 1 inside run_search too).
    run_search("tclr", 8'hC3, 0, 0, -1, dc, st);
    finish_check("tclr", 8'hC3, 1'b1, 1'b0, 4'd8, 9, dc);

    // Reset during the 4th trial aborts immediately.
    target = 8'h5A;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    cmp_valid = 1'b1;
    repeat (3) @(negedge clk);
    cmp_valid = 1'b0;
    check("rst pre trial_8", 16'(trial_8), 16'h50);
    check("rst pre trials", 16'(trials), 16'h3);
    #2 rst = 1'b1;
    #1;
    check("rst async outputs",
          {trial_valid, busy, done, found_eq, err, 3'b000, trial_8},
          16'h0000);
    check("rst async result", 16'(result), 16'h0);
    check("rst async trials", 16'(trials), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst no done", {14'h0, done, busy}, 16'h0);

    run_search("tpost", 8'h00, 0, 0, -1, dc, st);
    finish_check("tpost", 8'h00, 1'b0, 1'b0, 4'd8, 9, dc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
